// File: rtl/floppy_pkg.sv
// floppy_pkg -- shared definitions for the floppy head positioner.
//   TRK_W         : width of a track number
//   MAX_TRACK_DEF : default highest legal track (80-track drive)
//   ST_*          : seek_ctrl state encoding
//   trk_dist()    : unsigned distance between two track numbers
package floppy_pkg;

    localparam int unsigned TRK_W         = 7;
    localparam int unsigned MAX_TRACK_DEF = 79;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    function automatic logic [TRK_W-1:0] trk_dist(input logic [TRK_W-1:0] a,
                                                  input logic [TRK_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/seek_ctrl_step_timer.sv
// step_timer -- timing of one head step period.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start_i        : begin a period (accepted when idle or on the last cycle
//                    of the running period, giving back-to-back periods)
//   step_n_o       : registered active-low step pulse, low for the first
//                    PULSE_CYC cycles of each STEP_CYC-cycle period
//   period_end_o   : high on the last cycle of a period
module step_timer #(
    parameter int unsigned STEP_CYC  = 3000000,
    parameter int unsigned PULSE_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic step_n_o,
    output logic period_end_o
);

    localparam int unsigned CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          step_n_q, step_n_d;

    assign period_end_o = run_q && (cnt_q == CW'(STEP_CYC - 1));
    assign step_n_o     = step_n_q;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i && (!run_q || period_end_o)) begin
            run_d = 1'b1;
            cnt_d = '0;
        end else if (period_end_o) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Pulse decoded from next-state so step_n is a clean flop output
        // that falls on the very first cycle of the period.
        step_n_d = !(run_d && (cnt_d < CW'(PULSE_CYC)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            run_q    <= 1'b0;
            step_n_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            step_n_q <= step_n_d;
        end
    end

endmodule

// File: rtl/seek_ctrl.sv
// seek_ctrl -- floppy head seek / recalibrate controller.
//   clk, rst          : clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake (ready only in IDLE)
//   cmd_recal         : 1 = recalibrate to track 0, 0 = seek to cmd_track
//   cmd_track         : seek target
//   abort             : stop motion after the current step period
//   t00_sens          : raw asynchronous track-0 sensor (high = at track 0)
//   step_o, dir_o     : active-low step pulse, direction (1 = outward)
//   busy              : not idle
//   done, err         : one-cycle completion pulse, error flag with it
//   trk_valid         : head position known
//   cur_track         : current head position
// Build option: define SEEK_TR0_CHECK_EN to require the track-0 sensor to
// confirm any seek that ends at track 0.
module seek_ctrl
    import floppy_pkg::*;
#(
    parameter int unsigned STEP_CYC   = 3000000,
    parameter int unsigned PULSE_CYC  = 1000,
    parameter int unsigned SETTLE_CYC = 15000000,
    parameter int unsigned MAX_TRACK  = MAX_TRACK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_recal,
    input  logic [TRK_W-1:0] cmd_track,
    input  logic             abort,
    input  logic             t00_sens,
    output logic             step_o,
    output logic             dir_o,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             trk_valid,
    output logic [TRK_W-1:0] cur_track
);

    localparam int unsigned      SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned      RC_W        = TRK_W + 1;
    localparam logic [RC_W-1:0]  RECAL_LIMIT = RC_W'(MAX_TRACK + 4);

    logic [1:0]       t00_sync_q;
    logic             sens;
    logic [2:0]       state_q, state_d;
    logic             rdy_q;
    logic             dir_q, dir_d;
    logic             recal_q, recal_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;
    logic             trk_valid_q, trk_valid_d;
    logic [TRK_W-1:0] cur_q, cur_d;
    logic [TRK_W-1:0] remain_q, remain_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             start;
    logic             decide;
    logic             tr0_fail;
    logic             period_end;
    logic             step_n;

    assign sens = t00_sync_q[1];

    step_timer #(
        .STEP_CYC  (STEP_CYC),
        .PULSE_CYC (PULSE_CYC)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst),
        .start_i      (start),
        .step_n_o     (step_n),
        .period_end_o (period_end)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        recal_d     = recal_q;
        abort_d     = abort_q;
        err_d       = err_q;
        trk_valid_d = trk_valid_q;
        cur_d       = cur_q;
        remain_d    = remain_q;
        rcnt_d      = rcnt_q;
        settle_d    = settle_q;
        start       = 1'b0;
        decide      = 1'b0;

`ifdef SEEK_TR0_CHECK_EN
        tr0_fail = !recal_q && (cur_q == '0) && !sens;
`else
        tr0_fail = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && rdy_q) begin
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    recal_d = cmd_recal;
                    if (cmd_recal) begin
                        dir_d   = 1'b1;
                        rcnt_d  = '0;
                        state_d = ST_SETUP;
                    end else if (!trk_valid_q || (32'(cmd_track) > MAX_TRACK)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cmd_track == cur_q) begin
                        state_d = ST_DONE;
                    end else begin
                        dir_d    = (cmd_track < cur_q);
                        remain_d = trk_dist(cmd_track, cur_q);
                        state_d  = ST_SETUP;
                    end
                end
            end
            ST_SETUP: decide = 1'b1;
            ST_STEP: begin
                abort_d = abort_q | abort;
                decide  = period_end;
            end
            ST_SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == SW'(SETTLE_CYC - 1)) begin
                    settle_d = '0;
                    state_d  = ST_DONE;
                    if (tr0_fail) begin
                        err_d       = 1'b1;
                        trk_valid_d = 1'b0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Launch-or-finish decision, taken once in SETUP and then at the end
        // of every step period, so a new period starts back-to-back with the
        // previous one and the sensor is tested before each period.
        if (decide) begin
            if (abort_d) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
                // an interrupted recal leaves the position unknown
                if (recal_q) begin
                    trk_valid_d = 1'b0;
                end
            end else if (recal_q) begin
                if (sens) begin
                    cur_d       = '0;
                    trk_valid_d = 1'b1;
                    state_d     = ST_SETTLE;
                end else if (rcnt_q == RECAL_LIMIT) begin
                    trk_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    start   = 1'b1;
                    rcnt_d  = rcnt_q + 1'b1;
                    if (cur_q != '0) begin
                        cur_d = cur_q - 1'b1;
                    end
                    state_d = ST_STEP;
                end
            end else begin
                if (remain_q == '0) begin
                    state_d = ST_SETTLE;
                end else begin
                    start    = 1'b1;
                    remain_d = remain_q - 1'b1;
                    cur_d    = dir_q ? (cur_q - 1'b1) : (cur_q + 1'b1);
                    state_d  = ST_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t00_sync_q  <= '0;
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b0;
            dir_q       <= 1'b0;
            recal_q     <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            trk_valid_q <= 1'b0;
            cur_q       <= '0;
            remain_q    <= '0;
            rcnt_q      <= '0;
            settle_q    <= '0;
        end else begin
            t00_sync_q  <= {t00_sync_q[0], t00_sens};
            state_q     <= state_d;
            rdy_q       <= (state_d == ST_IDLE);
            dir_q       <= dir_d;
            recal_q     <= recal_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            trk_valid_q <= trk_valid_d;
            cur_q       <= cur_d;
            remain_q    <= remain_d;
            rcnt_q      <= rcnt_d;
            settle_q    <= settle_d;
        end
    end

    assign cmd_ready = rdy_q;
    assign step_o    = step_n;
    assign dir_o     = dir_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_DONE) && err_q;
    assign trk_valid = trk_valid_q;
    assign cur_track = cur_q;

endmodule

// File: tb/tb_seek_ctrl.sv
// tb_seek_ctrl -- scoreboard bench for seek_ctrl with a simple drive model:
// a physical head position moved by each step pulse drives the track-0 sensor.
module tb_seek_ctrl;

    localparam int STEP_CYC   = 8;
    localparam int PULSE_CYC  = 2;
    localparam int SETTLE_CYC = 4;
    localparam int MAXT       = 79;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_recal = 1'b0;
    logic [6:0] cmd_track = '0;
    logic       abort = 1'b0;
    logic       t00_sens;
    logic       cmd_ready, step_o, dir_o, busy, done, err, trk_valid;
    logic [6:0] cur_track;

    seek_ctrl #(
        .STEP_CYC   (STEP_CYC),
        .PULSE_CYC  (PULSE_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_recal (cmd_recal),
        .cmd_track (cmd_track),
        .abort     (abort),
        .t00_sens  (t00_sens),
        .step_o    (step_o),
        .dir_o     (dir_o),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .trk_valid (trk_valid),
        .cur_track (cur_track)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // drive model
    int phys = 3;
    bit sensor_broken = 1'b0;
    assign t00_sens = !sensor_broken && (phys == 0);

    // reference model of what the controller believes
    int m_pos = 0;
    bit m_valid = 1'b0;

    typedef struct {
        bit recal;
        int pulses;
        bit err;
        bit chk_cur;
        int cur;
        bit valid;
        bit dir;
        int acc;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    bit in_reset = 1'b1;
    int pulses_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input int expv);
        n_chk++;
        if (act !== 32'(expv)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // monitor
    initial begin
        int first_fall, last_fall, low_len, prev_cur;
        bit prev_step, prev_done;
        exp_t e;
        first_fall = 0; last_fall = 0; low_len = 0; prev_cur = 0;
        prev_step = 1'b1; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                if (prev_done) begin
                    chk("done_one_cycle", done, 0);
                    chk("ready_after_done", cmd_ready, 1);
                end
                if (step_o === 1'b0 && prev_step) begin
                    pulses_seen++;
                    if (pulses_seen == 1) first_fall = cyc;
                    else chk("step_period", cyc - last_fall, STEP_CYC);
                    last_fall = cyc;
                    low_len = 0;
                    if (exp_q.size() > 0 && !exp_q[0].recal)
                        chk("cur_on_fall", cur_track, dir_o ? prev_cur - 1 : prev_cur + 1);
                    if (dir_o) begin
                        if (phys > 0) phys = phys - 1;
                    end else begin
                        phys = phys + 1;
                    end
                end
                if (step_o === 1'b0) low_len++;
                else if (!prev_step) chk("pulse_width", low_len, PULSE_CYC);
                if (done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulses", pulses_seen, e.pulses);
                        chk("err", err, int'(e.err));
                        chk("trk_valid", trk_valid, int'(e.valid));
                        if (e.chk_cur) chk("cur_track", cur_track, e.cur);
                        if (e.pulses > 0) begin
                            chk("dir", dir_o, int'(e.dir));
                            chk("setup_lat", first_fall - e.acc, 1);
                            chk("done_lat", cyc - last_fall,
                                e.err ? STEP_CYC : STEP_CYC + SETTLE_CYC);
                        end else begin
                            chk("done_lat0", cyc - e.acc, e.recal ? 1 + SETTLE_CYC : 0);
                        end
                    end
                    pulses_seen = 0;
                end
            end
            prev_step = (step_o !== 1'b0);
            prev_done = (done === 1'b1) && !in_reset;
            prev_cur  = int'(cur_track);
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
    endtask

    // issue one command from a negedge and wait for its completion
    task automatic issue(input bit recal, input int trk, input int abort_k);
        exp_t e;
        int t, d, n;
        wait_ready();
        if (cmd_ready !== 1'b1) begin
            chk("ready_timeout", cmd_ready, 1);
            return;
        end
        e.recal = recal; e.pulses = 0; e.err = 1'b0; e.chk_cur = 1'b0;
        e.cur = 0; e.valid = m_valid; e.dir = 1'b1;
        if (recal) begin
            if (sensor_broken || phys > MAXT + 4) begin
                e.pulses = MAXT + 4; e.err = 1'b1; e.valid = 1'b0;
                m_valid = 1'b0;
            end else begin
                e.pulses = phys; e.valid = 1'b1; e.chk_cur = 1'b1; e.cur = 0;
                m_valid = 1'b1; m_pos = 0;
            end
        end else begin
            e.chk_cur = m_valid;
            e.cur = m_pos;
            if (!m_valid || trk > MAXT) begin
                e.err = 1'b1;
            end else if (trk != m_pos) begin
                d = (trk > m_pos) ? trk - m_pos : m_pos - trk;
                e.dir = (trk < m_pos);
                n = (abort_k > 0 && abort_k <= d) ? abort_k : d;
                e.pulses = n;
                e.err = (abort_k > 0);
                m_pos = e.dir ? m_pos - n : m_pos + n;
                e.cur = m_pos;
            end
        end
        cmd_valid = 1'b1;
        cmd_recal = recal;
        cmd_track = 7'(trk);
        e.acc = cyc + 1;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (e.pulses > 0) begin
            // commands offered while busy must be ignored
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_recal = 1'($urandom_range(0, 1));
            cmd_track = 7'($urandom_range(0, 127));
            repeat (2) @(negedge clk);
            cmd_valid = 1'b0;
        end
        if (abort_k > 0 && e.pulses > 0) begin
            t = 0;
            while (pulses_seen < abort_k && t < 2000) begin
                @(negedge clk);
                t++;
            end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        int t, tgt;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_step", step_o, 1);
        chk("rst_dir", dir_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", trk_valid, 0);
        chk("rst_track", cur_track, 0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_reset = 1'b0;
        chk("ready_after_reset", cmd_ready, 1);

        issue(1'b0, 5, 0);      // position unknown -> error
        issue(1'b1, 0, 0);      // sensor after 3 steps
        issue(1'b0, 5, 0);
        issue(1'b0, 5, 0);      // already there
        issue(1'b0, 90, 0);     // beyond last track
        issue(1'b0, 0, 0);
        issue(1'b0, 10, 2);     // abort during second period

        for (int i = 0; i < 24; i++) begin
            int r, trk, k;
            r = $urandom_range(0, 99);
            k = 0;
            if (r < 10) begin
                issue(1'b1, 0, 0);
            end else if (r < 22) begin
                issue(1'b0, $urandom_range(MAXT + 1, 127), 0);
            end else begin
                trk = $urandom_range(0, MAXT);
                if (r < 40 && trk != m_pos)
                    k = $urandom_range(1, (trk > m_pos) ? trk - m_pos : m_pos - trk);
                issue(1'b0, trk, k);
            end
        end

        sensor_broken = 1'b1;
        issue(1'b1, 0, 0);      // sensor never seen
        issue(1'b0, 3, 0);
        sensor_broken = 1'b0;
        issue(1'b1, 0, 0);
        issue(1'b0, 30, 0);

        // reset while a step pulse is low
        wait_ready();
        tgt = (m_pos > 40) ? 0 : MAXT;
        cmd_valid = 1'b1;
        cmd_recal = 1'b0;
        cmd_track = 7'(tgt);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (step_o !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("pulse_before_reset", step_o, 0);
        in_reset = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_step", step_o, 1);
        chk("mid_rst_dir", dir_o, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_valid", trk_valid, 0);
        chk("mid_rst_track", cur_track, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seek_ctrl.md
SEEK_CTRL -- requirements
Module: seek_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYC, default 3000000, meaning clocks per step period (3 ms at 1 GHz-equivalent scaling; set per board clock).
REQ-002 SHALL have parameter PULSE_CYC, default 1000, meaning active-low step pulse width in clocks (PULSE_CYC < STEP_CYC).
REQ-003 SHALL have parameter SETTLE_CYC, default 15000000, meaning head settle time in clocks after last step.
REQ-004 SHALL have parameter MAX_TRACK, default 79, meaning highest legal track.
REQ-005 SHALL have ports: clk in 1, sole clock; rst in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: cmd_valid in 1, command offered; cmd_ready out 1, command accepted when both high; cmd_recal in 1, 1 = recalibrate, 0 = seek; cmd_track in 7, seek target.
REQ-007 SHALL have ports: abort in 1, stop motion; t00_sens in 1, raw track-0 sensor, high = at track 0 (asynchronous).
REQ-008 SHALL have ports: step_o out 1, active-low step pulse; dir_o out 1, 1 = outward (toward track 0), 0 = inward.
REQ-009 SHALL have ports: busy out 1; done out 1, one-cycle completion pulse; err out 1, one-cycle error pulse (coincident with done); trk_valid out 1, position known; cur_track out 7, current position.

Function
REQ-010 SHALL synchronise t00_sens through two flops before use.
REQ-011 SHALL implement states IDLE, SETUP, STEP, SETTLE, DONE.
REQ-012 SHALL assert cmd_ready only in IDLE; cmd_valid outside IDLE is ignored.
REQ-013 On accept: drive dir_o, enter SETUP for exactly one cycle (direction setup), then STEP.
REQ-014 Each step period SHALL last STEP_CYC cycles, step_o low for its first PULSE_CYC cycles, high otherwise.
REQ-015 cur_track SHALL update (+1 inward, -1 outward) on the cycle step_o falls.
REQ-016 Seek: step count = |cmd_track - cur_track|; after last period enter SETTLE for SETTLE_CYC cycles, then DONE (done=1 one cycle), then IDLE.
REQ-017 Seek with cmd_track == cur_track SHALL skip SETUP/STEP/SETTLE: DONE the cycle after accept.
REQ-018 Seek with cmd_track > MAX_TRACK or trk_valid=0 SHALL produce no steps; DONE with err the cycle after accept.
REQ-019 Recal: dir_o=1; before each step period test synced sensor; if high, set cur_track=0, trk_valid=1, go SETTLE.
REQ-020 Recal exceeding MAX_TRACK+4 steps without sensor SHALL clear trk_valid, go DONE with err.
REQ-021 abort in STEP SHALL finish the current period (no truncated pulse), then DONE with err; abort elsewhere ignored.
REQ-022 busy SHALL be high in every state except IDLE.

Reset
REQ-023 Reset SHALL force IDLE, step_o=1, dir_o=0, busy=0, done=0, err=0, cmd_ready=0 during reset then 1, trk_valid=0, cur_track=0, all counters 0.
REQ-024 Reset mid-step SHALL release step_o high immediately (asynchronously).

Configuration
REQ-025 With SEEK_TR0_CHECK_EN defined, a seek ending at track 0 SHALL require synced sensor high at end of SETTLE; otherwise err with done and trk_valid cleared.
REQ-026 Without SEEK_TR0_CHECK_EN, no check; seek-to-0 ends like any seek.

Structure
REQ-027 Shared package floppy_pkg SHALL hold state encoding, TRK_W=7 and default MAX_TRACK.
REQ-028 Sub-module step_timer SHALL generate period/pulse timing (start, pulse-low, period-end strobe).

Verification (STEP_CYC=8, PULSE_CYC=2, SETTLE_CYC=4)
REQ-029 Sensor high after 3 steps, recal -> 3 low pulses, cur_track=0, trk_valid=1, done 4+ cycles after final period.
REQ-030 From track 0 seek 5 -> dir_o=0, 5 pulses 8 cycles apart each 2 low, cur_track=5, done once, err=0.
REQ-031 Seek 5 at track 5 -> no pulse, done next cycle; seek 90 -> no pulse, done+err.
REQ-032 Seek 0->10, abort after 2nd pulse -> period completes, cur_track=2, done+err, cmd_ready next cycle.
REQ-033 Sensor never high -> 83 pulses, done+err, trk_valid=0; rst low mid-pulse -> step_o=1 same cycle, all outputs reset.
